// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic enum, opcode/funct fields, link register,
// and the loader FSM state type.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OP_NOP,  OP_ADD,  OP_SUB,  OP_AND,  OP_OR,   OP_XOR,  OP_NOR,  OP_SLT,
        OP_SLL,  OP_SRL,  OP_JR,   OP_JALR, OP_ADDI, OP_ANDI, OP_SLTI, OP_BEQ,
        OP_BNE,  OP_LW,   OP_LH,   OP_SW,   OP_SH,   OP_J,    OP_JAL
    } mips_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_LH    = 6'h21;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SH    = 6'h29;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_XOR    = 6'h26;
    localparam logic [5:0] FN_NOR    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    localparam logic [4:0] REG_RA    = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_DONE
    } load_state_e;

    // Control-transfer instructions that own a branch delay slot.
    function automatic logic has_delay_slot(input logic [4:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR, OP_JALR};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational mnemonic + fields -> 32-bit MIPS machine word, flagging unknown mnemonics.
module instr_encode
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    function automatic logic [31:0] rtype(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                          input logic [4:0] f_rd, input logic [4:0] f_sh,
                                          input logic [5:0] fn);
        return {OPC_RTYPE, f_rs, f_rt, f_rd, f_sh, fn};
    endfunction

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            OP_NOP:  word = 32'h0;
            OP_ADD:  word = rtype(rs, rt, rd, shamt, FN_ADD);
            OP_SUB:  word = rtype(rs, rt, rd, shamt, FN_SUB);
            OP_AND:  word = rtype(rs, rt, rd, shamt, FN_AND);
            OP_OR:   word = rtype(rs, rt, rd, shamt, FN_OR);
            OP_XOR:  word = rtype(rs, rt, rd, shamt, FN_XOR);
            OP_NOR:  word = rtype(rs, rt, rd, shamt, FN_NOR);
            OP_SLT:  word = rtype(rs, rt, rd, shamt, FN_SLT);
            OP_SLL:  word = rtype(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:  word = rtype(5'd0, rt, rd, shamt, FN_SRL);
            OP_JR:   word = {OPC_RTYPE, rs, 15'd0, FN_JR};
            OP_JALR: word = rtype(rs, rt, REG_RA, shamt, FN_JALR);
            OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
            OP_ANDI: word = {OPC_ANDI, rs, rt, imm};
            OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
            OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:  word = {OPC_BNE, rs, rt, imm};
            OP_LW:   word = {OPC_LW, rs, rt, imm};
            OP_LH:   word = {OPC_LH, rs, rt, imm};
            OP_SW:   word = {OPC_SW, rs, rt, imm};
            OP_SH:   word = {OPC_SH, rs, rt, imm};
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams symbolic instructions into instruction memory at auto-incrementing word addresses.
// Define NOP_PAD_EN to append a zero delay-slot word after every branch/jump.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_op,
    output logic              err_ovf
);

    // Extra MSB marks that every IM word has been written.
    localparam logic [ADDR_W:0] BASE_CNT = BASE_ADDR[ADDR_W:0];

    load_state_e       state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              last_pend, last_pend_nxt;
    logic              we_nxt, done_nxt, err_op_nxt, err_ovf_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_nxt;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept, pad_req, cnt_full;

    instr_encode u_encode (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD) || (state == ST_PAD);
    assign accept   = in_valid & in_ready;
    assign cnt_full = cnt[ADDR_W];

`ifdef NOP_PAD_EN
    assign pad_req = has_delay_slot(in_op);
`else
    assign pad_req = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_pend_nxt = last_pend;
        we_nxt        = 1'b0;
        addr_nxt      = im_addr;
        wdata_nxt     = im_wdata;
        done_nxt      = done | (state == ST_DONE);
        err_op_nxt    = err_op;
        err_ovf_nxt   = err_ovf;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt     = ST_LOAD;
                    cnt_nxt       = BASE_CNT;
                    last_pend_nxt = 1'b0;
                    done_nxt      = 1'b0;
                    err_op_nxt    = 1'b0;
                    err_ovf_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_full) begin
                        err_ovf_nxt = 1'b1;
                        err_op_nxt  = err_op | enc_illegal;
                        state_nxt   = ST_DONE;
                        done_nxt    = 1'b1;
                    end else if (enc_illegal) begin
                        err_op_nxt = 1'b1;
                        if (in_last) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        we_nxt    = 1'b1;
                        addr_nxt  = cnt[ADDR_W-1:0];
                        wdata_nxt = enc_word;
                        cnt_nxt   = cnt + 1'b1;
                        if (pad_req) begin
                            state_nxt     = ST_PAD;
                            last_pend_nxt = in_last;
                        end else if (in_last) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (cnt_full) begin
                    err_ovf_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                    done_nxt    = 1'b1;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = cnt[ADDR_W-1:0];
                    wdata_nxt = 32'h0;
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = last_pend ? ST_DONE : ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_pend <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'h0;
            done      <= 1'b0;
            err_op    <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_pend <= last_pend_nxt;
            im_we     <= we_nxt;
            im_addr   <= addr_nxt;
            im_wdata  <= wdata_nxt;
            done      <= done_nxt;
            err_op    <= err_op_nxt;
            err_ovf   <= err_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table-driven reference model compared every cycle,
// directed literal cases, then randomized sessions with occasional resets.
module tb_instr_encode_loader;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;
`ifdef NOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // Per-mnemonic format (0 nop, 1 R, 2 I, 3 J, 4 jr, 5 jalr) and opcode/funct value.
    localparam int KIND [23] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 4, 5,
                                 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 3};
    localparam int CODE [23] = '{'h00, 'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h00, 'h02,
                                 'h08, 'h09, 'h08, 'h0C, 'h0A, 'h04, 'h05, 'h23, 'h21,
                                 'h2B, 'h29, 'h02, 'h03};

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [4:0] in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic in_ready, im_we, busy, done, err_op, err_ovf;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0] im_wdata;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err_op(err_op), .err_ovf(err_ovf)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Returns {illegal, word}.
    function automatic logic [32:0] model_word(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [15:0] imm, input logic [25:0] tg);
        logic [5:0] c;
        if (op < 0 || op > 22) return {1'b1, 32'h0};
        c = 6'(CODE[op]);
        case (KIND[op])
            0:       return {1'b0, 32'h0};
            1:       return {1'b0, 6'h00, (op == 8 || op == 9) ? 5'd0 : rs, rt, rd, sh, c};
            2:       return {1'b0, c, rs, rt, imm};
            3:       return {1'b0, c, tg};
            4:       return {1'b0, 6'h00, rs, 15'd0, c};
            default: return {1'b0, 6'h00, rs, rt, 5'd31, sh, c};
        endcase
    endfunction

    function automatic bit model_delay_slot(input int op);
        return (op == 10 || op == 11 || op == 15 || op == 16 || op == 21 || op == 22);
    endfunction

    bit m_active, m_pad_due, m_last_pend, m_finished, m_done, m_eop, m_eovf, m_we, chk_en;
    int m_addr, m_wa;
    logic [31:0] m_wd;

    initial begin
        logic [32:0] r;
        forever begin
            @(posedge clk);
            m_we = 1'b0;
            if (!rst) begin
                m_active = 0; m_pad_due = 0; m_last_pend = 0; m_finished = 0;
                m_done = 0; m_eop = 0; m_eovf = 0; m_addr = 0; chk_en = 1;
            end else if (start && !m_active) begin
                m_active = 1; m_pad_due = 0; m_finished = 0; m_done = 0;
                m_eop = 0; m_eovf = 0; m_addr = BASE_ADDR;
            end else if (m_active && m_pad_due) begin
                m_pad_due = 0;
                if (m_addr >= DEPTH) begin
                    m_eovf = 1; m_active = 0; m_finished = 1; m_done = 1;
                end else begin
                    m_we = 1; m_wa = m_addr; m_wd = 32'h0; m_addr++;
                    if (m_last_pend) begin m_active = 0; m_finished = 1; end
                end
            end else if (m_active && in_valid) begin
                r = model_word(int'(in_op), in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
                if (m_addr >= DEPTH) begin
                    m_eovf = 1; if (r[32]) m_eop = 1;
                    m_active = 0; m_finished = 1; m_done = 1;
                end else if (r[32]) begin
                    m_eop = 1;
                    if (in_last) begin m_active = 0; m_finished = 1; m_done = 1; end
                end else begin
                    m_we = 1; m_wa = m_addr; m_wd = r[31:0]; m_addr++;
                    if (PAD_EN && model_delay_slot(int'(in_op))) begin
                        m_pad_due = 1; m_last_pend = in_last;
                    end else if (in_last) begin
                        m_active = 0; m_finished = 1;
                    end
                end
            end else if (m_finished) begin
                m_done = 1;
            end
        end
    end

    typedef struct { int cyc; logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
    wr_t wr_log[$];
    int cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (im_we === 1'b1) wr_log.push_back('{cyc, im_addr, im_wdata});
            if (chk_en) begin
                check("ctrl{ready,busy,done,err_op,err_ovf,we}",
                      64'({in_ready, busy, done, err_op, err_ovf, im_we}),
                      64'({m_active && !m_pad_due, m_active, m_done, m_eop, m_eovf, m_we}));
                if (m_we)
                    check("write{addr,data}", 64'({im_addr, im_wdata}),
                          64'({ADDR_W'(m_wa), m_wd}));
            end
        end
    end

    function automatic logic [63:0] log_at(input int i);
        if (i >= wr_log.size()) return 'x;
        return 64'({wr_log[i].a, wr_log[i].d});
    endfunction

    function automatic logic [63:0] log_gap(input int i);
        if (i + 1 >= wr_log.size()) return 'x;
        return 64'(wr_log[i+1].cyc - wr_log[i].cyc);
    endfunction

    function automatic logic [63:0] ent(input int a, input logic [31:0] d);
        return 64'({ADDR_W'(a), d});
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tg,
                        input bit last);
        int n = 0;
        in_valid = 1'b1; in_op = 5'(op); in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tg; in_last = last;
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("send handshake", 64'(in_ready), 64'(1));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Pin the reference model against hand-encoded words.
        check("model add",  64'(model_word(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0)),  64'({1'b0, 32'h00221820}));
        check("model addi", 64'(model_word(12, 5'd0, 5'd2, 5'd0, 5'd0, 16'h5, 26'h0)), 64'({1'b0, 32'h20020005}));
        check("model lw",   64'(model_word(17, 5'd1, 5'd4, 5'd0, 5'd0, 16'h8, 26'h0)), 64'({1'b0, 32'h8C240008}));
        check("model sll",  64'(model_word(8, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0)),  64'({1'b0, 32'h00011100}));
        check("model j",    64'(model_word(21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10)), 64'({1'b0, 32'h08000010}));
        check("model beq",  64'(model_word(15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0)), 64'({1'b0, 32'h1022FFFF}));
        check("model illegal", 64'(model_word(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0) >> 32), 64'(1));

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", 64'({in_ready, im_we, im_addr, im_wdata, busy, done, err_op, err_ovf}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        wr_log.delete();
        pulse_start();
        send(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        idle(3);
        check("add count", 64'(wr_log.size()), 64'(1));
        check("add word", log_at(0), ent(0, 32'h00221820));
        check("add done", 64'({done, busy}), 64'(2'b10));

        wr_log.delete();
        pulse_start();
        send(12, 5'd0, 5'd2, 5'd0, 5'd0, 16'h5, 26'h0, 1'b0);
        send(17, 5'd1, 5'd4, 5'd0, 5'd0, 16'h8, 26'h0, 1'b1);
        idle(3);
        check("b2b word0", log_at(0), ent(0, 32'h20020005));
        check("b2b word1", log_at(1), ent(1, 32'h8C240008));
        check("b2b gap", log_gap(0), 64'(1));

        wr_log.delete();
        pulse_start();
        send(8, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
        send(21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        idle(3);
        check("sll word", log_at(0), ent(0, 32'h00011100));
`ifdef NOP_PAD_EN
        check("j word", log_at(1), ent(1, 32'h08000010));
        check("j pad", log_at(2), ent(2, 32'h0));
`else
        check("j word", log_at(1), ent(1, 32'h08000010));
        check("j count", 64'(wr_log.size()), 64'(2));
`endif

        wr_log.delete();
        pulse_start();
        send(15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        send(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        idle(4);
        check("beq word", log_at(0), ent(0, 32'h1022FFFF));
`ifdef NOP_PAD_EN
        check("beq pad", log_at(1), ent(1, 32'h0));
        check("beq add", log_at(2), ent(2, 32'h00221820));
        check("beq gaps", 64'({log_gap(0), log_gap(1)} != 128'({64'd1, 64'd1})), 64'(0));
`else
        check("beq add", log_at(1), ent(1, 32'h00221820));
        check("beq count", 64'(wr_log.size()), 64'(2));
`endif

        wr_log.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send(2, 5'(i), 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0);
        idle(3);
        check("ovf count", 64'(wr_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("ovf addr", 64'(wr_log.size() > i ? int'(wr_log[i].a) : -1), 64'(i));
        check("ovf flags", 64'({err_ovf, done, busy, err_op}), 64'(4'b1100));

        wr_log.delete();
        pulse_start();
        check("restart clears", 64'({err_ovf, done}), 64'(0));
        send(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        send(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        idle(3);
        check("illegal count", 64'(wr_log.size()), 64'(1));
        check("illegal holds addr", log_at(0), ent(0, 32'h00221820));
        check("illegal err_op", 64'(err_op), 64'(1));

        wr_log.delete();
        pulse_start();
        send(25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        in_valid = 1'b0;
        check("illegal last done", 64'({done, busy, im_we}), 64'(3'b100));
        idle(2);

        wr_log.delete();
        pulse_start();
        send(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        in_op = 5'd12; in_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("mid reset outputs", 64'({in_ready, im_we, im_addr, im_wdata, busy, done, err_op, err_ovf}), 64'(0));
        rst = 1'b1;
        idle(4);
        check("mid reset no write", 64'(wr_log.size()), 64'(1));

        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 22));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        rst = 1'b1; start = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Streaming MIPS instruction encoder and instruction-memory loader for the hw3 pipeline. It accepts one symbolic instruction per handshake (mnemonic enum plus register, shift, immediate and target fields) and emits the 32-bit machine word the pipeline controller decodes. It writes that word into instruction memory at an auto-incrementing word address. It sits between the testbench/boot source and the IM write port, and is the encode side of the controller's opcode/funct decode.

## Interface
Parameters:
- `ADDR_W`, 8: IM word-address width; depth = 2^ADDR_W words.
- `BASE_ADDR`, 0: first word address written after `start`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load session at `BASE_ADDR`.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  encoder accepts this cycle.
- `in_op`  in  5  mnemonic enum: NOP, ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, JR, JALR, ADDI, ANDI, SLTI, BEQ, BNE, LW, LH, SW, SH, J, JAL.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_imm`  in  16  I-type immediate/offset, already in word-offset form for branches.
- `in_target`  in  26  J-type target field.
- `in_last`  in  1  marks the final instruction of the session.
- `im_we`  out  1  IM write strobe.
- `im_addr`  out  ADDR_W  IM word address.
- `im_wdata`  out  32  encoded instruction.
- `busy`  out  1  session active.
- `done`  out  1  session finished; held until next `start`.
- `err_op`  out  1  sticky: illegal `in_op` seen.
- `err_ovf`  out  1  sticky: write past last IM word attempted.

## Operation
- FSM states: IDLE, LOAD, PAD, DONE.
  - IDLE/DONE + `start` → LOAD. Address counter = `BASE_ADDR`; `done`, `err_op` and `err_ovf` clear.
  - `start` during LOAD or PAD is ignored.
- `in_ready` = (state==LOAD). Acceptance = `in_valid & in_ready`.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. Functs: add 20, sub 22, and 24, or 25, xor 26, nor 27, slt 2A, sll 00, srl 02.
  - SLL/SRL force rs=0.
  - JR: {0, rs, 15'b0, 6'h08}.
  - JALR: rd forced to 31, funct 6'h09.
  - I-type: {opcode, rs, rt, imm}. Opcodes: addi 08, andi 0C, slti 0A, beq 04, bne 05, lw 23, lh 21, sw 2B, sh 29.
  - J-type: {opcode, target}. Opcodes: j 02, jal 03.
  - NOP = 32'h0.
- Illegal `in_op`: word not written, counter unchanged, `err_op` set. The accepted `in_last` still ends the session.
- After each write the counter increments by 1.
- Overflow: an accept when the counter already wrapped past 2^ADDR_W−1 suppresses the write, sets `err_ovf`, and goes to DONE.
- Accepted `in_last` (write or no write) → DONE after its write, or after its PAD when `NOP_PAD_EN` is defined.

## Timing
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `busy`=0, `done`=0, `err_op`=0, `err_ovf`=0. State = IDLE.
- Reset mid-session aborts immediately. No partial write follows.
- Latency: an accept at edge N drives registered `im_we`/`im_addr`/`im_wdata` during cycle N+1, for one cycle only.
- Back-to-back accepts give one write per cycle with consecutive addresses.
- `busy` = state ∈ {LOAD, PAD}.
- `done` rises in the cycle after the last write, or after the accept if no write occurred.

## Configuration
- `NOP_PAD_EN` defined:
  - After every accepted BEQ, BNE, J, JAL, JR or JALR, the FSM enters PAD for one cycle.
  - During PAD, `in_ready`=0, and a 32'h0 delay-slot word is written at the next address in the following cycle.
  - PAD is subject to the same overflow rule.
- `NOP_PAD_EN` undefined: PAD is unreachable, and branches and jumps are written without a delay-slot word.

## Structure
- Shared package `mips_isa_pkg` holds:
  - the mnemonic enum;
  - opcode and funct localparams, which the controller decode also uses;
  - the register-31 constant.
- Sub-module `instr_encode` is a purely combinational mnemonic+fields → {word, illegal} function. The FSM, counter and output registers live in the top level.

## Test plan
- After `start`: ADD rs=1 rt=2 rd=3 → `im_addr`=0, `im_wdata`=32'h00221820 one cycle after the accept.
- ADDI rs=0 rt=2 imm=5, then LW rs=1 rt=4 imm=8 back-to-back → 32'h20020005 at addr 0, 32'h8C240008 at addr 1 on consecutive cycles.
- SLL rt=1 rd=2 shamt=4 with rs=7 → 32'h00011100 (rs forced 0). J target=0x10 → 32'h08000010.
- With `NOP_PAD_EN`: BEQ rs=1 rt=2 imm=16'hFFFF, then ADD → writes 32'h1022FFFF, 32'h0, then ADD at addr+2. `in_ready` is low for one cycle.
- `ADDR_W`=2: five accepts → four writes at addresses 0..3. The fifth sets `err_ovf`, reaches DONE, and produces no write.
- Illegal op code 31 → no `im_we`, `err_op`=1, counter holds. Assert `rst` low mid-stream → all outputs 0 and IDLE on the next edge.
